adc_frame_packetizer: RTL and testbench
=======================================

Name: adc_frame_packetizer

Overview:
- Sits directly downstream of the AD5592R ADC SPI interface.
- Captures each completed 8-channel, 128-bit ADC snapshot and serializes it into a framed byte packet for the telemetry UART transmitter. The packet carries a header, sequence number, channel data and checksum.
- Holds at most one pending snapshot while a packet is in flight, and counts the snapshots it drops.

Parameters:
- NUM_CH, 8, number of 16-bit channels per frame; frame width = 16*NUM_CH.
- HDR0, 8'hA5, first header byte.
- HDR1, 8'h5A, second header byte.

Ports:
- CLK, input, 1, system clock; all logic on rising edge.
- RST, input, 1, synchronous active-high reset.
- FRAME_DATA, input, 16*NUM_CH, ADC snapshot; CH0 in [15:0], CH7 in [127:112].
- FRAME_VALID, input, 1, one-cycle strobe; FRAME_DATA valid this cycle.
- TX_DATA, output, 8, byte to the UART transmitter.
- TX_VALID, output, 1, TX_DATA valid.
- TX_READY, input, 1, transmitter accepts the byte.
- BUSY, output, 1, high while a packet is being sent (state != IDLE).
- DROP_COUNT, output, 8, number of dropped frames; saturates at 255.

Behaviour:
- Clock and reset (already decided): one clock, CLK; reset is synchronous and active-high, RST.
- Reset values: TX_DATA=0, TX_VALID=0, BUSY=0, DROP_COUNT=0, sequence counter=0, pending buffer empty, state=IDLE.
- Reset mid-packet: the partial packet is abandoned and TX_VALID=0 from the next cycle. No recovery byte is sent.
- Capture: FRAME_VALID high at an edge loads FRAME_DATA into a pending register and sets pend_full.
- Drop: if pend_full is already set and the pending frame is not consumed at the same edge:
  - the new frame overwrites the pending frame;
  - DROP_COUNT increments, saturating at 255.
- Simultaneous consume and capture: the old pending frame moves to the shift buffer and the new frame becomes pending. No drop.
- Handshake: a byte transfers on any edge where TX_VALID && TX_READY. TX_DATA and TX_VALID are registered and held stable until transfer. TX_VALID never drops without a transfer, except on reset.
- State machine:
  - IDLE: if pend_full, copy pending to the shift buffer, clear pend_full, TX_DATA<=HDR0, TX_VALID<=1, go to S_HDR0. Latency from FRAME_VALID edge to TX_VALID high is 2 cycles when idle.
  - S_HDR0: on transfer, present HDR1, go to S_HDR1.
  - S_HDR1: on transfer, present the sequence byte, go to S_SEQ.
  - S_SEQ: on transfer, present the first data byte, go to S_DATA with byte index 0.
  - S_DATA: bytes are sent CH0 first, high byte before low byte, 2*NUM_CH bytes in total. After the last byte transfers, present the checksum, go to S_CSUM.
  - S_CSUM: on transfer, drop TX_VALID, increment the sequence counter (255 wraps to 0), go to IDLE. Back-to-back packets therefore have one idle cycle between them.
- Checksum: modulo-256 sum of the sequence byte and all data bytes. Header bytes are excluded. Accumulated in an 8-bit register as bytes are presented.
- Packet length: 3 + 2*NUM_CH + 1 = 20 bytes at the default NUM_CH.

Optional Feature:
- Macro: ADC_PKT_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset to 0, wraps) is latched into the pending register alongside FRAME_DATA at capture.
  - State S_TS sends the latched counter, high byte then low byte, between S_SEQ and S_DATA. Both bytes are included in the checksum.
  - The packet is 22 bytes.
- Undefined: no counter and no S_TS; the packet is exactly as above.

Test Plan:
- Single frame, TX_READY held high:
  - Stimulus: CH0..CH7 = 16'h0001..16'h0008.
  - Response: A5 5A 00 00 01 00 02 00 03 00 04 00 05 00 06 00 07 00 08 24, one byte per cycle.
  - Afterwards BUSY=0 and the next packet carries sequence 01.
- Backpressure:
  - Stimulus: same frame, TX_READY toggled 1,0,0,1 repeating.
  - Response: TX_DATA and TX_VALID are held stable while TX_READY=0, the byte sequence is identical, and no byte is duplicated or skipped.
- Overflow:
  - Stimulus: frames A, B and C strobed 3 cycles apart while packet A is in flight.
  - Response: DROP_COUNT=1 and packets A then C are sent; B is never sent.
- Consume/capture collision:
  - Stimulus: FRAME_VALID coincides with the IDLE edge that consumes the pending frame.
  - Response: both frames are sent and DROP_COUNT=0.
- Reset mid-packet:
  - Stimulus: RST asserted for 1 cycle after byte 7 transfers.
  - Response: TX_VALID=0 next cycle; a following frame starts with A5 5A 00.
- Sequence wrap:
  - Stimulus: 257 frames, each sent to completion.
  - Response: the sequence byte goes 00..FF then 00. With ADC_PKT_TIMESTAMP_EN, the first packet is 22 bytes and its timestamp equals the counter value at capture.

Source files
------------

// File: rtl/adc_frame_packetizer.sv
// Serializes captured 8-channel ADC snapshots into framed UART byte packets:
// HDR0 HDR1 SEQ [TS_HI TS_LO] DATA... CSUM. Optional macro: ADC_PKT_TIMESTAMP_EN.
module adc_frame_packetizer #(
    parameter int         NUM_CH = 8,
    parameter logic [7:0] HDR0   = 8'hA5,
    parameter logic [7:0] HDR1   = 8'h5A
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [16*NUM_CH-1:0]  FRAME_DATA,
    input  logic                  FRAME_VALID,
    output logic [7:0]            TX_DATA,
    output logic                  TX_VALID,
    input  logic                  TX_READY,
    output logic                  BUSY,
    output logic [7:0]            DROP_COUNT
);

    localparam int NB = 2 * NUM_CH;
    localparam int FW = 16 * NUM_CH;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_SEQ,
`ifdef ADC_PKT_TIMESTAMP_EN
        S_TS,
`endif
        S_DATA,
        S_CSUM
    } state_t;

    state_t          state;
    logic [FW-1:0]   pend_data;
    logic            pend_full;
    logic [FW+15:0]  shift_buf;
    logic [IW-1:0]   byte_idx;
    logic [7:0]      seq;
    logic [7:0]      csum;
    logic            xfer;
    logic            consume;
    logic [7:0]      next_data;

`ifdef ADC_PKT_TIMESTAMP_EN
    logic [15:0]     cyc_cnt;
    logic [15:0]     pend_ts;
    logic [15:0]     ts_buf;
    logic            ts_lo;
`endif

    assign xfer    = TX_VALID && TX_READY;
    assign consume = (state == S_IDLE) && pend_full;
    assign BUSY    = (state != S_IDLE);

    // The buffer shifts one channel after each low byte, so the next byte is
    // either the low byte of the current channel or the high byte of the next.
    assign next_data = byte_idx[0] ? shift_buf[31:24] : shift_buf[7:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_IDLE;
            TX_DATA    <= '0;
            TX_VALID   <= 1'b0;
            DROP_COUNT <= '0;
            seq        <= '0;
            csum       <= '0;
            pend_full  <= 1'b0;
            pend_data  <= '0;
            shift_buf  <= '0;
            byte_idx   <= '0;
`ifdef ADC_PKT_TIMESTAMP_EN
            cyc_cnt    <= '0;
            pend_ts    <= '0;
            ts_buf     <= '0;
            ts_lo      <= 1'b0;
`endif
        end else begin
`ifdef ADC_PKT_TIMESTAMP_EN
            cyc_cnt <= cyc_cnt + 16'd1;
`endif
            if (FRAME_VALID) begin
                pend_data <= FRAME_DATA;
                pend_full <= 1'b1;
`ifdef ADC_PKT_TIMESTAMP_EN
                pend_ts   <= cyc_cnt;
`endif
                if (pend_full && !consume && DROP_COUNT != 8'hFF)
                    DROP_COUNT <= DROP_COUNT + 8'd1;
            end else if (consume) begin
                pend_full <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pend_full) begin
                        shift_buf <= {16'h0000, pend_data};
`ifdef ADC_PKT_TIMESTAMP_EN
                        ts_buf    <= pend_ts;
`endif
                        TX_DATA   <= HDR0;
                        TX_VALID  <= 1'b1;
                        state     <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    if (xfer) begin
                        TX_DATA <= HDR1;
                        state   <= S_HDR1;
                    end
                end
                S_HDR1: begin
                    if (xfer) begin
                        TX_DATA <= seq;
                        csum    <= seq;
                        state   <= S_SEQ;
                    end
                end
                S_SEQ: begin
                    if (xfer) begin
`ifdef ADC_PKT_TIMESTAMP_EN
                        TX_DATA <= ts_buf[15:8];
                        csum    <= csum + ts_buf[15:8];
                        ts_lo   <= 1'b0;
                        state   <= S_TS;
`else
                        TX_DATA  <= shift_buf[15:8];
                        csum     <= csum + shift_buf[15:8];
                        byte_idx <= '0;
                        state    <= S_DATA;
`endif
                    end
                end
`ifdef ADC_PKT_TIMESTAMP_EN
                S_TS: begin
                    if (xfer) begin
                        if (!ts_lo) begin
                            TX_DATA <= ts_buf[7:0];
                            csum    <= csum + ts_buf[7:0];
                            ts_lo   <= 1'b1;
                        end else begin
                            TX_DATA  <= shift_buf[15:8];
                            csum     <= csum + shift_buf[15:8];
                            byte_idx <= '0;
                            state    <= S_DATA;
                        end
                    end
                end
`endif
                S_DATA: begin
                    if (xfer) begin
                        if (byte_idx == LAST_IDX) begin
                            TX_DATA <= csum;
                            state   <= S_CSUM;
                        end else begin
                            TX_DATA  <= next_data;
                            csum     <= csum + next_data;
                            byte_idx <= byte_idx + IW'(1);
                            if (byte_idx[0])
                                shift_buf <= shift_buf >> 16;
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        TX_VALID <= 1'b0;
                        seq      <= seq + 8'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Scoreboard bench for adc_frame_packetizer: stimulus pushes expected packet
// bytes, a negedge monitor pops and compares on every accepted byte.
module tb_adc_frame_packetizer;

    localparam int NUM_CH = 8;

    logic                 CLK;
    logic                 RST;
    logic [16*NUM_CH-1:0] FRAME_DATA;
    logic                 FRAME_VALID;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 BUSY;
    logic [7:0]           DROP_COUNT;

    adc_frame_packetizer #(.NUM_CH(NUM_CH), .HDR0(8'hA5), .HDR1(8'h5A)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FRAME_DATA (FRAME_DATA),
        .FRAME_VALID(FRAME_VALID),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .DROP_COUNT (DROP_COUNT)
    );

    int          total = 0;
    int          bad   = 0;
    int          n_rx  = 0;
    int          ready_mode = 0;
    int          pat = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_seq = 8'h00;
    logic [15:0] tcyc = 16'h0000;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference cycle counter used for the optional timestamp field.
    initial begin
        forever begin
            @(posedge CLK);
            if (RST) tcyc = 16'h0000;
            else     tcyc = tcyc + 16'd1;
        end
    end

    initial begin
        TX_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #2;
            case (ready_mode)
                0: TX_READY = 1'b1;
                1: begin
                    TX_READY = (pat == 0) || (pat == 3);
                    pat = (pat + 1) % 4;
                end
                default: TX_READY = 1'b0;
            endcase
        end
    end

    // Monitor: transfer is decided at the coming posedge, sampled at negedge.
    initial begin
        logic       prev_stall;
        logic       prev_rst;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = '0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (prev_stall && !prev_rst) begin
                    chk("hold_valid", {31'd0, TX_VALID}, 32'd1);
                    chk("hold_data", {24'd0, TX_DATA}, {24'd0, prev_data});
                end
                if (TX_VALID && TX_READY) begin
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_byte", {24'd0, TX_DATA}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d", n_rx), {24'd0, TX_DATA}, {24'd0, e});
                    end
                end
            end
            prev_stall = TX_VALID && !TX_READY && !RST;
            prev_rst   = RST;
            prev_data  = TX_DATA;
        end
    end

    task automatic push_packet(input logic [7:0] s, input logic [16*NUM_CH-1:0] f,
                               input logic [15:0] ts);
        logic [7:0] sum;
        logic [7:0] hi;
        logic [7:0] lo;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(s);
        sum = s;
`ifdef ADC_PKT_TIMESTAMP_EN
        exp_q.push_back(ts[15:8]);
        exp_q.push_back(ts[7:0]);
        sum = sum + ts[15:8] + ts[7:0];
`else
        if (ts != 16'h0000) sum = sum;
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            hi = f[16*c+8 +: 8];
            lo = f[16*c   +: 8];
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            sum = sum + hi + lo;
        end
        exp_q.push_back(sum);
    endtask

    task automatic send_frame(input logic [16*NUM_CH-1:0] f, input bit sent);
        FRAME_DATA  = f;
        FRAME_VALID = 1'b1;
        if (sent) begin
            push_packet(exp_seq, f, tcyc);
            exp_seq = exp_seq + 8'd1;
        end
        @(posedge CLK);
        #1;
        FRAME_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(posedge CLK);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_drain_timeout"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    function automatic logic [127:0] mk(input logic [15:0] base, input logic [15:0] step);
        logic [127:0] f;
        for (int c = 0; c < NUM_CH; c++) f[16*c +: 16] = base + step * 16'(c);
        return f;
    endfunction

    initial begin
        logic [7:0]   v1 [20];
        logic [127:0] f1;
        int           base;
        int           k;

        RST = 1'b1;
        FRAME_VALID = 1'b0;
        FRAME_DATA = '0;
        idle(3);
        RST = 1'b0;
        chk("rst_tx_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rst_tx_data", {24'd0, TX_DATA}, 32'd0);
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_drop", {24'd0, DROP_COUNT}, 32'd0);

        // Single frame, hand-computed packet.
        f1 = {16'h0008, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
`ifdef ADC_PKT_TIMESTAMP_EN
        send_frame(f1, 1'b1);
`else
        v1 = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00,
               8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h24};
        for (int i = 0; i < 20; i++) exp_q.push_back(v1[i]);
        exp_seq = 8'h01;
        FRAME_DATA = f1;
        FRAME_VALID = 1'b1;
        idle(1);
        FRAME_VALID = 1'b0;
        chk("lat_valid_low", {31'd0, TX_VALID}, 32'd0);
        idle(1);
        chk("lat_valid_high", {31'd0, TX_VALID}, 32'd1);
`endif
        drain("single");
        chk("single_busy", {31'd0, BUSY}, 32'd0);
        chk("single_valid", {31'd0, TX_VALID}, 32'd0);

        // Backpressure 1,0,0,1 with the same frame; sequence now 01.
        pat = 0;
        ready_mode = 1;
        send_frame(f1, 1'b1);
        drain("backpressure");
        ready_mode = 0;
        idle(2);

        // Capture on the same edge that consumes the pending frame.
        send_frame(mk(16'h1234, 16'h1111), 1'b1);
        send_frame(mk(16'hFEDC, 16'h0F0F), 1'b1);
        drain("collision");
        idle(2);
        chk("collision_drop", {24'd0, DROP_COUNT}, 32'd0);

        // Overflow: B is overwritten by C while A is in flight.
        send_frame(mk(16'hA000, 16'h0101), 1'b1);
        idle(2);
        send_frame(mk(16'hB000, 16'h0202), 1'b0);
        idle(2);
        send_frame(mk(16'hC000, 16'h0303), 1'b1);
        chk("overflow_drop", {24'd0, DROP_COUNT}, 32'd1);
        drain("overflow");
        idle(2);
        chk("overflow_drop_end", {24'd0, DROP_COUNT}, 32'd1);

        // Reset mid-packet after the 7th byte of the packet transfers.
        base = n_rx;
        send_frame(mk(16'h5555, 16'h0001), 1'b1);
        k = 0;
        while (n_rx < base + 7 && k < 200) begin
            @(posedge CLK);
            #1;
            k++;
        end
        chk("reset_reach_byte7", n_rx - base, 32'd7);
        exp_q.delete();
        ready_mode = 2;
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        ready_mode = 0;
        exp_seq = 8'h00;
        chk("midrst_valid", {31'd0, TX_VALID}, 32'd0);
        chk("midrst_busy", {31'd0, BUSY}, 32'd0);
        chk("midrst_drop", {24'd0, DROP_COUNT}, 32'd0);
        idle(3);
        chk("midrst_no_resume", {31'd0, TX_VALID}, 32'd0);
        send_frame(mk(16'h0BAD, 16'h0110), 1'b1);
        drain("after_reset");
        idle(2);

        // Sequence wrap across 257 packets.
        for (int i = 0; i < 257; i++) begin
            send_frame(mk(16'(i * 7), 16'(i + 3)), 1'b1);
            drain("wrap");
        end
        idle(3);
        chk("end_busy", {31'd0, BUSY}, 32'd0);
        chk("end_drop", {24'd0, DROP_COUNT}, 32'd0);
        chk("end_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
